// File: rtl/comb_behav.sv
// comb_behav: registers Y = (~A & B) | (C & ~D) computed four ways (gates, dataflow, behavioral, UDP).
// Define COMB_BEHAV_SELFCHECK_EN to build the mismatch comparator and saturating error counter.

primitive comb_behav_udp (y, a, b, c, d);
  output y;
  input a, b, c, d;
  table
  // a b c d : y
    0 0 0 0 : 0;
    0 0 0 1 : 0;
    0 0 1 0 : 1;
    0 0 1 1 : 0;
    0 1 0 0 : 1;
    0 1 0 1 : 1;
    0 1 1 0 : 1;
    0 1 1 1 : 1;
    1 0 0 0 : 0;
    1 0 0 1 : 0;
    1 0 1 0 : 1;
    1 0 1 1 : 0;
    1 1 0 0 : 0;
    1 1 0 1 : 0;
    1 1 1 0 : 1;
    1 1 1 1 : 0;
  endtable
endprimitive

module comb_behav #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  output logic             out_valid,
  output logic             y_str,
  output logic             y_dataflow,
  output logic             y_behavior,
  output logic             y_prim,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt
);

  logic [3:0] n;
  assign n = {d, c, b, a};

  wire not_a;
  wire not_d;
  wire term_ab;
  wire term_cd;
  wire str_y;

  not g_not_a (not_a, a);
  not g_not_d (not_d, d);
  and g_and_ab (term_ab, not_a, b);
  and g_and_cd (term_cd, c, not_d);
  or  g_or (str_y, term_ab, term_cd);

  logic df_y;
  assign df_y = (~a & b) | (c & ~d);

  logic beh_y;
  always_comb begin
    beh_y = 1'b0;
    case (n)
      4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10, 4'd14: beh_y = 1'b1;
      default: beh_y = 1'b0;
    endcase
  end

  wire prim_y;
  comb_behav_udp u_prim (prim_y, a, b, c, d);

  // Invalid cycles keep the last results so the monitor always sees a stable value.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      y_str      <= 1'b0;
      y_dataflow <= 1'b0;
      y_behavior <= 1'b0;
      y_prim     <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y_str      <= str_y;
        y_dataflow <= df_y;
        y_behavior <= beh_y;
        y_prim     <= prim_y;
      end
    end
  end

`ifdef COMB_BEHAV_SELFCHECK_EN
  assign mismatch = !((y_str == y_dataflow) && (y_str == y_behavior) && (y_str == y_prim));

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (out_valid && mismatch && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
`else
  assign mismatch = 1'b0;
  assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_comb_behav.sv
// tb_comb_behav: directed and random checks of comb_behav against a lookup-set reference model.
// Self-check expectations follow COMB_BEHAV_SELFCHECK_EN when the bench is built with it.

module tb_comb_behav;

  localparam int CNT_W = 2;
  localparam int ERR_MAX = (1 << CNT_W) - 1;
`ifdef COMB_BEHAV_SELFCHECK_EN
  localparam bit SELFCHECK = 1'b1;
`else
  localparam bit SELFCHECK = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             a, b, c, d;
  logic             out_valid;
  logic             y_str, y_dataflow, y_behavior, y_prim;
  logic             mismatch;
  logic [CNT_W-1:0] err_cnt;

  comb_behav #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .out_valid  (out_valid),
    .y_str      (y_str),
    .y_dataflow (y_dataflow),
    .y_behavior (y_behavior),
    .y_prim     (y_prim),
    .mismatch   (mismatch),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  logic exp_y = 1'b0;
  logic exp_prim = 1'b0;
  logic exp_valid = 1'b0;
  logic exp_mismatch = 1'b0;
  int   exp_err = 0;
  bit   forcing = 1'b0;
  logic forced_val = 1'b0;

  function automatic logic refY(input int n);
    return (n inside {2, 4, 5, 6, 7, 10, 14});
  endfunction

  task automatic checkSignal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkSignal("y_str", {7'd0, y_str}, {7'd0, exp_y});
    checkSignal("y_dataflow", {7'd0, y_dataflow}, {7'd0, exp_y});
    checkSignal("y_behavior", {7'd0, y_behavior}, {7'd0, exp_y});
    checkSignal("y_prim", {7'd0, y_prim}, {7'd0, exp_prim});
    checkSignal("out_valid", {7'd0, out_valid}, {7'd0, exp_valid});
    checkSignal("mismatch", {7'd0, mismatch}, {7'd0, exp_mismatch});
    checkSignal("err_cnt", {6'd0, err_cnt}, 8'(exp_err));
  endtask

  // One clock of stimulus, then advance the reference model and compare.
  task automatic applyStimulus(input logic r, input logic iv, input logic [3:0] n);
    rst = r;
    in_valid = iv;
    {d, c, b, a} = n;
    if (forcing) begin
      forced_val = ~refY(int'(n));
      force dut.prim_y = forced_val;
    end
    @(posedge clk);
    #1;
    if (r) begin
      exp_y = 1'b0;
      exp_prim = 1'b0;
      exp_valid = 1'b0;
      exp_err = 0;
    end else begin
      if (exp_valid && exp_mismatch && exp_err < ERR_MAX) exp_err++;
      exp_valid = iv;
      if (iv) begin
        exp_y = refY(int'(n));
        exp_prim = forcing ? ~exp_y : exp_y;
      end
    end
    exp_mismatch = SELFCHECK && (exp_prim != exp_y);
    checkOutput();
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    {d, c, b, a} = 4'd0;

    // Reset held two cycles with a valid n=4 pending, then the first real result.
    applyStimulus(1'b1, 1'b1, 4'd4);
    applyStimulus(1'b1, 1'b1, 4'd4);
    applyStimulus(1'b0, 1'b1, 4'd4);

    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 4'(i));

    applyStimulus(1'b0, 1'b1, 4'd2);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 4'd0);

    applyStimulus(1'b0, 1'b1, 4'd4);
    applyStimulus(1'b0, 1'b1, 4'd5);
    applyStimulus(1'b1, 1'b1, 4'd6);
    applyStimulus(1'b0, 1'b1, 4'd7);

    for (int i = 0; i < 60; i++)
      applyStimulus(($urandom_range(15) == 0), ($urandom_range(3) != 0), 4'($urandom_range(15)));

    // Inverted primitive path for five valid cycles exercises the comparator and saturation.
    applyStimulus(1'b1, 1'b0, 4'd0);
    forcing = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 4'($urandom_range(15)));
    forcing = 1'b0;
    release dut.prim_y;
    applyStimulus(1'b0, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b1, 4'd10);
    applyStimulus(1'b0, 1'b1, 4'd12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
